// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo-MODULUS counter with synchronous load,
// wrap or saturate ends, terminal count and registered event pulses.
// Ports: clk, reset (sync, active-high), en, up_dn, load, load_val[W]
//        -> count[W] (reg), tc (comb), evt (reg pulse), load_err (reg pulse).
// Optional macro COUNTER_MATCH_EN adds match_val[W] -> match (reg).
module updown_mod_counter #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_MATCH_EN
    input  logic [WIDTH-1:0] match_val,
    output logic             match,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             evt,
    output logic             load_err
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("updown_mod_counter: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_mod
        $error("updown_mod_counter: MODULUS must be 2..2**WIDTH");
    end

    // Highest legal count, held as a WIDTH-bit constant so every compare
    // stays WIDTH bits wide even when MODULUS = 2**WIDTH.
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] count_nxt;
    logic             evt_nxt;
    logic             err_nxt;

    assign at_top = (count == MAX);
    assign at_bot = (count == '0);

    // Gated by reset so a cascaded stage never sees a stray enable.
    assign tc = en & ~reset & ((up_dn & at_top) | (~up_dn & at_bot));

    always_comb begin
        count_nxt = count;
        evt_nxt   = 1'b0;
        err_nxt   = 1'b0;
        if (load) begin
            // load_val > MAX is the same test as load_val >= MODULUS.
            if (load_val > MAX) begin
                count_nxt = MAX;
                err_nxt   = 1'b1;
            end else begin
                count_nxt = load_val;
            end
        end else if (en) begin
            if (up_dn) begin
                if (at_top) begin
                    count_nxt = SATURATE ? MAX : '0;
                    evt_nxt   = 1'b1;
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end else begin
                if (at_bot) begin
                    count_nxt = SATURATE ? '0 : MAX;
                    evt_nxt   = 1'b1;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            evt      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_nxt;
            evt      <= evt_nxt;
            load_err <= err_nxt;
        end
    end

`ifdef COUNTER_MATCH_EN
    // Compare the resolved next count so match lines up with the new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            match <= 1'b0;
        end else begin
            match <= (count_nxt == match_val);
        end
    end
`endif

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the team's 4-bit free-running up counter.
- Width and modulus are configurable. Direction is selectable at run time. Synchronous load, count enable, wrap or saturate mode, terminal-count output and a registered event pulse.
- Used standalone as a cycle/event counter. Can also be cascaded through `tc` to build wider counters in later lab designs.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- MODULUS, 16, count range is 0..MODULUS-1; legal range 2..2^WIDTH. Out-of-range values raise an elaboration error via generate-time check.
- SATURATE, 0, boundary handling. 0 = wrap around at the ends; 1 = hold at the end value.

Ports:
- clk  input  1  system clock, rising edge only
- reset  input  1  synchronous, active-high reset
- en  input  1  count enable
- up_dn  input  1  direction: 1 = up, 0 = down
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  value to load
- count  output  WIDTH  current count, registered
- tc  output  1  terminal count, combinational
- evt  output  1  one-cycle pulse, registered; marks a wrap or saturation hit
- load_err  output  1  one-cycle pulse, registered; marks an out-of-range load

Behaviour:
- Clocking and reset:
  - Single clock domain; all state changes on posedge clk.
  - reset is synchronous and active-high; when it is high at a rising edge, count=0, evt=0 and load_err=0 after that edge.
  - tc=0 while reset is held, because it is gated by the reset input.
- Priority per edge: reset > load > en > hold.
- Load:
  - If load_val < MODULUS: count <= load_val.
  - Else: count <= MODULUS-1 and load_err <= 1 for one cycle.
  - Load ignores en and up_dn, and never asserts evt.
- Count, en=1 and load=0:
  - Up, count < MODULUS-1: count+1.
  - Up, count == MODULUS-1: 0 if SATURATE=0, else hold MODULUS-1. evt=1 next cycle in both modes.
  - Down, count > 0: count-1.
  - Down, count == 0: MODULUS-1 if SATURATE=0, else hold 0. evt=1 next cycle in both modes.
- en=0 and load=0: count holds; evt=0 and load_err=0.
- tc = en & ~reset & ((up_dn & count==MODULUS-1) | (~up_dn & count==0)).
  - Purely combinational, for a ripple-enable cascade into the next stage's en.
- Direction change:
  - up_dn may change on any cycle; it takes effect at the next edge, with no dead cycle.
  - An up_dn toggle at a boundary value is evaluated with the new direction. Example: count=0, up_dn flips to 1, so count goes to 1 with no evt.
- Saturate mode: evt re-asserts on every enabled cycle spent at the end value, i.e. each blocked increment or decrement.
- Comparisons:
  - All arithmetic is WIDTH bits, unsigned.
  - Comparisons against MODULUS-1 use a WIDTH-bit constant.
  - No intermediate overflow is possible when MODULUS = 2^WIDTH.
- Reset mid-operation: takes priority over a simultaneous load or count. Pending evt/load_err pulses are cleared.

Optional Feature:
- Macro: COUNTER_MATCH_EN.
- When defined, the block gains two extra ports:
  - match_val  input  WIDTH
  - match  output  1
- match is registered: it is 1 in the cycle after count is updated to equal match_val, so it reflects the new count. Reset value is 0.
- match is evaluated after load and count resolution, so a load of match_val also raises match.
- When not defined, neither port exists and no compare logic is generated.

Test Plan:
- WIDTH=4, MODULUS=10, SATURATE=0; reset high 2 cycles, then en=1, up_dn=1 for 12 cycles -> count 0,1,..,9,0,1. evt high exactly one cycle, the cycle after 9->0. tc high only while count=9.
- Same configuration, count=0 with en=1, up_dn=0 -> count 9,8,7. evt pulses once after 0->9. tc=1 at count=0.
- SATURATE=1: load 8, then up for 4 cycles -> 8,9,9,9,9. evt high for 3 consecutive cycles, one per blocked increment. Down from 0 holds at 0.
- load=1 with load_val=13 (MODULUS=10) -> count=9, load_err one-cycle pulse, no evt. load_val=5 with en=1 simultaneously -> count=5, load wins.
- Reset asserted mid-count at count=6, with load=1 and load_val=3 in the same cycle -> count=0, evt=0, load_err=0. tc=0 while reset is high.
- Cascade two instances (MODULUS=10), lower tc driving upper en; run 100 cycles -> upper:lower reads 9:9 at cycle 99 and 0:0 at cycle 100. With COUNTER_MATCH_EN and match_val=7 on the lower instance -> match pulses once per decade.
